field_extract_pipe: RTL
=======================

Name: field_extract_pipe

Overview:
- Parametrised, pipelined successor to the combinational sign-extension unit.
- Extracts an arbitrary bit field from a WIDTH-bit operand, right-justifies it, then sign- or zero-extends it.
- Two register stages with valid/ready handshakes on both sides. Sits between the operand-fetch and execute stages of the VCPU-32 datapath, serving EXTR-class instructions.
- Bit 0 is the MSB, matching the VCPU-32 datapath numbering.

Parameters:
- WIDTH, 32, operand and result width; power of two, 8..64.
- POS_W, $clog2(WIDTH), width of the pos and len fields; derived, not overridden.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  source operand.
- b  in  WIDTH  deposit target operand; ignored unless FIELD_DEPOSIT_EN is defined.
- pos  in  POS_W  bit index of the field's rightmost (least significant) bit, 0 = MSB.
- len  in  POS_W  field length; 0 encodes WIDTH.
- sign  in  1  1 = sign-extend, 0 = zero-extend.
- mode  in  1  0 = extract, 1 = deposit (deposit only with FIELD_DEPOSIT_EN).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  result.
- err  out  1  field underflowed bit 0; qualifies y.

Behaviour:
Reset:
- rst low clears both stage valid bits asynchronously: out_valid=0, y=0, err=0.
- in_ready=1 while rst is high and the pipe is empty.
- Reset asserted mid-operation drops all in-flight requests; no partial results are emitted.

Handshake:
- A transfer occurs on any clock edge where valid & ready.
- in_ready = !v1 | in_ready_2, where in_ready_2 = !v2 | out_ready. This is a full-throughput chain.
- Stage 2 output holds y and err stable while out_valid & !out_ready.
- Accepting at edge N gives out_valid at edge N+2. Throughput is 1 per cycle when out_ready is held high.

Stage 1 (registered):
- Registers a, b, mode and sign.
- Registers an effective length L = (len==0) ? WIDTH : len.
- Registers right-shift amount s = WIDTH-1-pos.
- Registers err1 = (L > pos+1).
- On err1, L is clamped to pos+1, so the field is bits 0..pos.

Stage 2 (registered):
- Extract: f = (a >> s) & mask(L). Sign bit is f[WIDTH-L], i.e. field MSB.
  - sign=1 and field MSB=1: y = f | ~mask(L).
  - Otherwise: y = f.
- L=WIDTH: y = a, regardless of sign.
- err = err1.

Boundaries:
- pos=WIDTH-1, len=1 extracts the LSB alone.
- Simultaneous input accept and output drain in the same cycle must not lose or duplicate data.
- in_valid with in_ready=0 is held by the producer; the block does not sample it.
- mode=1 without FIELD_DEPOSIT_EN is treated as extract.

Optional Feature:
Macro FIELD_DEPOSIT_EN.
- Defined:
  - mode=1 computes y = (b & ~M) | ((a & mask(L)) << s), where M = mask(L) << s.
  - sign is ignored in this mode.
  - err and clamping are identical to extract.
- Undefined:
  - b and mode are unconnected internally and no deposit logic is synthesised.
  - Latency and handshake are unchanged.

Test Plan:
1. a=0x000000FF, pos=31, len=8, sign=1 → y=0xFFFFFFFF, err=0, out_valid two edges after accept. Same request with sign=0 → y=0x000000FF.
2. a=0x12345678, pos=23, len=8, sign=1 → y=0x00000056. Also a=0x00F00000, pos=11, len=4, sign=1 → y=0xFFFFFFFF. Also len=0, pos=31 → y=a.
3. a=0xFFFFFFFF, pos=2, len=8, sign=0 → err=1, y=0x00000007.
4. Backpressure: out_ready=0, issue 3 back-to-back requests → first two accepted, in_ready=0 on the third. Raise out_ready → all three emerge in order with no loss or duplication. Streaming with out_ready=1 → one result per cycle.
5. Reset: assert rst low with both stages valid → out_valid=0 and y=0 immediately, without waiting for a clock. After release → in_ready=1 and no stale output.
6. With FIELD_DEPOSIT_EN: b=0x00000000, a=0x000000AB, pos=15, len=8, mode=1 → y=0x00AB0000. Also b=0xFFFFFFFF, a=0, pos=31, len=4 → y=0xFFFFFFF0.

Source files
------------

// File: rtl/field_extract_pipe.sv
// Two-stage pipelined bit-field extractor with MSB-0 numbering and valid/ready on both sides.
// Define FIELD_DEPOSIT_EN to add the deposit (mode=1) datapath; otherwise b and mode are ignored.
module field_extract_pipe #(
  parameter  int WIDTH = 32,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [POS_W-1:0] pos,
  input  logic [POS_W-1:0] len,
  input  logic             sign,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  localparam logic [POS_W:0]   L_FULL   = (POS_W+1)'(WIDTH);
  localparam logic [POS_W:0]   L_ONE    = (POS_W+1)'(1);
  localparam logic [POS_W-1:0] LAST_BIT = POS_W'(WIDTH-1);

  logic             v1, v2, in_ready_2;
  logic [WIDTH-1:0] a1;
  logic             sign1, err1;
  logic [POS_W:0]   len1;
  logic [POS_W-1:0] sh1;

`ifdef FIELD_DEPOSIT_EN
  logic [WIDTH-1:0] b1;
  logic             mode1;
`else
  logic unused_deposit;
  assign unused_deposit = ^{b, mode};
`endif

  assign in_ready_2 = !v2 || out_ready;
  assign in_ready   = !v1 || in_ready_2;
  assign out_valid  = v2;

  // Effective length with len==0 meaning WIDTH, clamped so the field never runs past bit 0.
  logic [POS_W:0] len_eff, pos_p1, len_clamp;
  logic           err_in;

  always_comb begin
    len_eff   = (len == '0) ? L_FULL : {1'b0, len};
    pos_p1    = {1'b0, pos} + L_ONE;
    err_in    = len_eff > pos_p1;
    len_clamp = err_in ? pos_p1 : len_eff;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      a1    <= '0;
      sign1 <= 1'b0;
      err1  <= 1'b0;
      len1  <= '0;
      sh1   <= '0;
`ifdef FIELD_DEPOSIT_EN
      b1    <= '0;
      mode1 <= 1'b0;
`endif
    end else begin
      if (in_ready) v1 <= in_valid;
      if (in_valid && in_ready) begin
        a1    <= a;
        sign1 <= sign;
        err1  <= err_in;
        len1  <= len_clamp;
        sh1   <= LAST_BIT - pos;
`ifdef FIELD_DEPOSIT_EN
        b1    <= b;
        mode1 <= mode;
`endif
      end
    end
  end

  // mask_top isolates the field MSB so the sign test needs no variable bit index.
  logic [WIDTH-1:0] mask, mask_top, field, y_next;
  logic             field_msb;

  always_comb begin
    mask      = (len1 == L_FULL) ? '1 : ((WIDTH'(1) << len1) - WIDTH'(1));
    mask_top  = mask ^ (mask >> 1);
    field     = (a1 >> sh1) & mask;
    field_msb = |(field & mask_top);
    y_next    = (sign1 && field_msb) ? (field | ~mask) : field;
`ifdef FIELD_DEPOSIT_EN
    if (mode1) y_next = (b1 & ~(mask << sh1)) | ((a1 & mask) << sh1);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2  <= 1'b0;
      y   <= '0;
      err <= 1'b0;
    end else if (in_ready_2) begin
      v2 <= v1;
      if (v1) begin
        y   <= y_next;
        err <= err1;
      end
    end
  end

endmodule
